main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 32, byte-address width of cm_ReadAddr.
REQ-002 SHALL have parameter DATA_WIDTH, 32, word width.
REQ-003 SHALL have parameter TAG_WIDTH, 30, width of cm_WriteTag, which is the word address.
REQ-004 SHALL have parameter MEM_WORDS, 1024, backing-store depth in words (power of two).
REQ-005 SHALL have parameter READ_LATENCY, 4, request-to-response cycles; legal range 1..255.
REQ-006 CLK  input  1  clock; all state changes on rising edge.
REQ-007 Reset  input  1  reset, synchronous, active-high.
REQ-008 cm_ReadValid  input  1  read request; held high by the cache until serviced.
REQ-009 cm_ReadAddr  input  ADDR_WIDTH  byte address of the requested word.
REQ-010 cm_ReadReady  output  1  one-cycle pulse: cm_ReadData valid, request serviced.
REQ-011 cm_ReadData  output  DATA_WIDTH  read word; 0 whenever cm_ReadReady is low.
REQ-012 cm_WriteValid  input  1  write-back strobe, fire-and-forget, no handshake.
REQ-013 cm_WriteTag  input  TAG_WIDTH  word address of the write-back.
REQ-014 cm_WriteData  input  DATA_WIDTH  write-back word.
REQ-015 busy  output  1  high while a read is accepted and not yet responded.
REQ-016 rd_count  output  16  serviced-read counter, saturating.
REQ-017 wr_count  output  16  accepted-write counter, saturating.

Function
REQ-018 Word index SHALL be addr[log2(MEM_WORDS)+1:2] for reads and cm_WriteTag[log2(MEM_WORDS)-1:0] for writes; upper bits ignored (aliasing wraps).
REQ-019 Read FSM SHALL have states IDLE, WAIT, RESP.
REQ-020 IDLE: cm_ReadValid high in cycle 0 SHALL latch the word index and go to WAIT, or to RESP directly when READ_LATENCY==1.
REQ-021 WAIT SHALL count down so that RESP is occupied in cycle READ_LATENCY exactly.
REQ-022 RESP SHALL drive cm_ReadReady=1 and cm_ReadData=mem[latched index] for one cycle, then return to IDLE unconditionally.
REQ-023 Latched index SHALL NOT change during WAIT/RESP even if cm_ReadAddr changes.
REQ-024 cm_ReadValid low in any WAIT cycle SHALL abort to IDLE: no pulse, rd_count unchanged.
REQ-025 After RESP, the IDLE cycle SHALL evaluate cm_ReadValid as cycle 0 of a new request; minimum request spacing is READ_LATENCY+1 cycles.
REQ-026 cm_WriteValid high in any cycle and any state SHALL write mem[index] at the next edge.
REQ-027 A write in the RESP cycle to the latched index SHALL be forwarded: cm_ReadData returns cm_WriteData.
REQ-028 busy SHALL be high in WAIT and RESP, low in IDLE.
REQ-029 rd_count SHALL increment on each RESP cycle; wr_count SHALL increment on each write cycle; both hold at 16'hFFFF.
REQ-030 Memory contents SHALL initialise to 0 at time zero and SHALL NOT be cleared by Reset.

Reset
REQ-031 Reset SHALL force IDLE, cm_ReadReady=0, cm_ReadData=0, busy=0, rd_count=0, wr_count=0, and clear the latency counter.
REQ-032 Reset during WAIT/RESP SHALL drop the pending read with no pulse; a write in the Reset cycle SHALL still update memory.

Verification
REQ-033 Write tag 0x5, data 0xDEADBEEF; then read addr 0x14 at cycle 0 -> cm_ReadReady=1, data 0xDEADBEEF at cycle 4 only; rd_count=1, wr_count=1.
REQ-034 READ_LATENCY=1 build: read addr 0x0 at cycle 0 -> pulse at cycle 1 with data 0; busy high only at cycle 1.
REQ-035 Drop cm_ReadValid at cycle 2 (latency 4) -> no pulse through cycle 10; busy=0 from cycle 3; rd_count unchanged.
REQ-036 Write tag 0x9, data 0x12345678 in the RESP cycle of a read of addr 0x24 -> cm_ReadData=0x12345678.
REQ-037 Read addr 0x1000 after write tag 0x400, data 0xA5A5A5A5 (MEM_WORDS=1024) -> returns 0xA5A5A5A5 (alias of index 0).
REQ-038 Assert Reset at cycle 2 of a read -> no pulse, busy=0, counters 0; a new read at the cycle after reset completes at its cycle 4.

Source files
------------

// File: rtl/main_mem_responder.sv
// Word-addressed backing store that answers cache read requests after a
// fixed latency and absorbs fire-and-forget write-backs.
module main_mem_responder #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_WIDTH    = 30,
  parameter int MEM_WORDS    = 1024,
  parameter int READ_LATENCY = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  cm_ReadValid,
  input  logic [ADDR_WIDTH-1:0] cm_ReadAddr,
  output logic                  cm_ReadReady,
  output logic [DATA_WIDTH-1:0] cm_ReadData,
  input  logic                  cm_WriteValid,
  input  logic [TAG_WIDTH-1:0]  cm_WriteTag,
  input  logic [DATA_WIDTH-1:0] cm_WriteData,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [7:0] LOAD =
    (READ_LATENCY >= 2) ? 8'(READ_LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   rd_idx, wr_idx;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     rd_count_q, rd_count_d;
  logic [15:0]     wr_count_q, wr_count_d;
  logic            resp, fwd;

  // Contents survive Reset; only time zero clears them.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

  assign rd_idx = cm_ReadAddr[IW+1:2];
  assign wr_idx = cm_WriteTag[IW-1:0];

  logic unused_bits;
  assign unused_bits = ^{cm_ReadAddr[ADDR_WIDTH-1:IW+2],
                         cm_ReadAddr[1:0],
                         cm_WriteTag[TAG_WIDTH-1:IW]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cm_ReadValid) begin
          idx_d   = rd_idx;
          cnt_d   = LOAD;
          state_d = (READ_LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!cm_ReadValid) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == 8'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset masks a response already in flight this cycle.
  assign resp = (state_q == RESP) && !Reset;
  assign fwd  = cm_WriteValid && (wr_idx == idx_q);

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (resp && rd_count_q != 16'hFFFF)
      rd_count_d = rd_count_q + 16'd1;
    if (cm_WriteValid && wr_count_q != 16'hFFFF)
      wr_count_d = wr_count_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= 8'd0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (cm_WriteValid)
      mem[wr_idx] <= cm_WriteData;
  end

  assign cm_ReadReady = resp;
  assign cm_ReadData  = resp ? (fwd ? cm_WriteData : mem[idx_q])
                             : '0;
  assign busy         = (state_q != IDLE) && !Reset;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: latency-4 instance for most
// scenarios, latency-1 instance for the single-cycle path.
module tb_main_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        rv, wv;
  logic [31:0] ra, wd;
  logic [29:0] wt;
  logic        rdy, busy;
  logic [31:0] rdata;
  logic [15:0] rdc, wrc;

  logic        r1v;
  logic [31:0] r1a;
  logic        w1v;
  logic [29:0] w1t;
  logic [31:0] w1d;
  logic        rdy1, busy1;
  logic [31:0] rdata1;
  logic [15:0] rdc1, wrc1;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  main_mem_responder #(.READ_LATENCY(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .cm_ReadValid(rv), .cm_ReadAddr(ra),
    .cm_ReadReady(rdy), .cm_ReadData(rdata),
    .cm_WriteValid(wv), .cm_WriteTag(wt), .cm_WriteData(wd),
    .busy(busy), .rd_count(rdc), .wr_count(wrc)
  );

  main_mem_responder #(.READ_LATENCY(1)) dut1 (
    .CLK(CLK), .Reset(Reset),
    .cm_ReadValid(r1v), .cm_ReadAddr(r1a),
    .cm_ReadReady(rdy1), .cm_ReadData(rdata1),
    .cm_WriteValid(w1v), .cm_WriteTag(w1t), .cm_WriteData(w1d),
    .busy(busy1), .rd_count(rdc1), .wr_count(wrc1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  initial begin
    Reset = 1'b1;
    rv = 0; ra = 0; wv = 0; wt = 0; wd = 0;
    r1v = 0; r1a = 0; w1v = 0; w1t = 0; w1d = 0;
    nxt();
    nxt();
    smp();
    chk("rst rdy", {31'd0, rdy}, 32'd0);
    chk("rst data", rdata, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst rdc", {16'd0, rdc}, 32'd0);
    chk("rst wrc", {16'd0, wrc}, 32'd0);
    nxt();
    Reset = 1'b0;

    // latency 1: pulse in cycle 1 only
    for (int k = 0; k <= 2; k++) begin
      r1v = (k < 2);
      r1a = 32'h0;
      smp();
      chk($sformatf("l1 rdy c%0d", k), {31'd0, rdy1}, {31'd0, k == 1});
      chk($sformatf("l1 busy c%0d", k), {31'd0, busy1}, {31'd0, k == 1});
      chk($sformatf("l1 data c%0d", k), rdata1, 32'd0);
      nxt();
    end
    r1v = 0;
    smp();
    chk("l1 rdc", {16'd0, rdc1}, 32'd1);
    nxt();

    // write tag 5, read byte addr 0x14
    wv = 1; wt = 30'h5; wd = 32'hDEADBEEF;
    smp();
    nxt();
    wv = 0;
    for (int k = 0; k <= 4; k++) begin
      rv = 1; ra = 32'h14;
      smp();
      chk($sformatf("t1 rdy c%0d", k), {31'd0, rdy}, {31'd0, k == 4});
      chk($sformatf("t1 data c%0d", k), rdata,
          (k == 4) ? 32'hDEADBEEF : 32'd0);
      chk($sformatf("t1 busy c%0d", k), {31'd0, busy}, {31'd0, k >= 1});
      nxt();
    end
    rv = 0;
    smp();
    chk("t1 rdc", {16'd0, rdc}, 32'd1);
    chk("t1 wrc", {16'd0, wrc}, 32'd1);
    nxt();

    // abort: valid dropped in cycle 2
    for (int k = 0; k <= 10; k++) begin
      rv = (k < 2); ra = 32'h14;
      smp();
      chk($sformatf("ab rdy c%0d", k), {31'd0, rdy}, 32'd0);
      chk($sformatf("ab busy c%0d", k), {31'd0, busy},
          {31'd0, (k == 1) || (k == 2)});
      nxt();
    end
    smp();
    chk("ab rdc", {16'd0, rdc}, 32'd1);
    nxt();

    // write forwarded in the RESP cycle
    for (int k = 0; k <= 4; k++) begin
      rv = 1; ra = 32'h24;
      wv = (k == 4); wt = 30'h9; wd = 32'h12345678;
      smp();
      chk($sformatf("fw rdy c%0d", k), {31'd0, rdy}, {31'd0, k == 4});
      chk($sformatf("fw data c%0d", k), rdata,
          (k == 4) ? 32'h12345678 : 32'd0);
      nxt();
    end
    rv = 0; wv = 0;
    smp();
    chk("fw rdc", {16'd0, rdc}, 32'd2);
    chk("fw wrc", {16'd0, wrc}, 32'd2);
    nxt();

    // alias: tag 0x400 lands on index 0, byte addr 0x1000 too
    wv = 1; wt = 30'h400; wd = 32'hA5A5A5A5;
    smp();
    nxt();
    wv = 0;
    for (int k = 0; k <= 4; k++) begin
      rv = 1; ra = 32'h1000;
      smp();
      chk($sformatf("al rdy c%0d", k), {31'd0, rdy}, {31'd0, k == 4});
      chk($sformatf("al data c%0d", k), rdata,
          (k == 4) ? 32'hA5A5A5A5 : 32'd0);
      nxt();
    end
    rv = 0;
    smp();
    chk("al rdc", {16'd0, rdc}, 32'd3);
    chk("al wrc", {16'd0, wrc}, 32'd3);
    nxt();

    // reset in cycle 2 of a read; write in that cycle still lands
    for (int k = 0; k <= 2; k++) begin
      rv = 1; ra = 32'h14;
      Reset = (k == 2);
      wv = (k == 2); wt = 30'h7; wd = 32'h77;
      smp();
      chk($sformatf("rs rdy c%0d", k), {31'd0, rdy}, 32'd0);
      if (k < 2)
        chk($sformatf("rs busy c%0d", k), {31'd0, busy}, {31'd0, k >= 1});
      nxt();
    end
    Reset = 0; wv = 0;
    for (int k = 0; k <= 4; k++) begin
      rv = 1; ra = 32'h1C;
      smp();
      if (k == 0) begin
        chk("rs busy after", {31'd0, busy}, 32'd0);
        chk("rs rdc after", {16'd0, rdc}, 32'd0);
        chk("rs wrc after", {16'd0, wrc}, 32'd0);
      end
      chk($sformatf("rs2 rdy c%0d", k), {31'd0, rdy}, {31'd0, k == 4});
      chk($sformatf("rs2 data c%0d", k), rdata,
          (k == 4) ? 32'h77 : 32'd0);
      nxt();
    end
    rv = 0;
    smp();
    chk("rs2 rdc", {16'd0, rdc}, 32'd1);
    chk("rs2 wrc", {16'd0, wrc}, 32'd0);
    chk("rs2 busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
